dtc_vote_accumulator: RTL and testbench
=======================================

Name: dtc_vote_accumulator

Overview:
- Downstream stage of the decision-tree classifier blocks. It consumes the 7-bit class vector the tree produces for each 8-bit feature sample.
- Accumulates per-bit hit counts over a fixed window of WINDOW samples and emits one majority-voted 7-bit result per window.
- Uses valid/ready handshakes on both sides.
- Smooths per-sample classifier noise before results reach downstream control logic.

Parameters:
- WIDTH, 7: width of the classifier output vector and the voted result.
- WINDOW, 8: samples per vote window; legal range 1..255.
- THRESH, 5: minimum hit count for a result bit to be set; legal range 1..WINDOW.
- CNT_W, 8: width of the per-bit and sample counters; must satisfy 2^CNT_W > WINDOW.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of the current window or pending result.
- in_valid  input  1  in_bits carries a classifier output.
- in_ready  output  1  block accepts a sample this cycle.
- in_bits  input  WIDTH  classifier output vector for one sample.
- out_valid  output  1  out_bits holds a voted result.
- out_ready  input  1  downstream accepts the result.
- out_bits  output  WIDTH  voted result.
- out_samples  output  CNT_W  number of samples in the emitted window; always WINDOW.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=ACCUM.
  - All hit counters and the sample counter = 0.
  - out_valid=0, out_bits=0, out_samples=0.
  - in_ready reads 1 the first cycle after rst_n rises.
- FSM has two states, ACCUM and EMIT.
- ACCUM:
  - in_ready = !flush (combinational).
  - Accept = in_valid && in_ready.
  - On accept: hit_cnt[i] += in_bits[i] for every i; sample_cnt += 1.
  - When an accept brings sample_cnt to WINDOW, in the same edge:
    - out_bits[i] <= (hit_cnt[i] + in_bits[i] >= THRESH).
    - out_samples <= WINDOW.
    - out_valid <= 1; state <= EMIT.
    - All counters cleared.
  - Latency: out_valid is high the cycle after the last sample of the window is accepted.
- EMIT:
  - in_ready=0; in_valid is ignored and no sample is lost, because upstream holds it.
  - out_bits and out_samples stay stable while out_valid && !out_ready.
  - When out_valid && out_ready: out_valid <= 0 and state <= ACCUM, so in_ready is 1 the next cycle. out_bits holds its last value; it is don't-care while out_valid=0.
- flush:
  - Highest synchronous priority, valid in any state.
  - Next edge: state=ACCUM, counters cleared, out_valid=0.
  - A sample presented in the same cycle is not accepted, since in_ready=0.
  - A pending result in EMIT is discarded even if out_ready=1 that cycle; no transfer occurs.
- Arithmetic:
  - Counters are unsigned CNT_W bits and never exceed WINDOW, so no saturation logic is needed.
  - The comparison uses the sum including the final sample, extended to CNT_W+1 bits.
- WINDOW=1: every accepted sample produces a result on the next cycle.
  - THRESH=1 gives out_bits equal to in_bits.
- Reset mid-window or mid-EMIT: the partial window and the pending result are lost; no output is produced for them.
- Throughput: one window result per WINDOW+1 cycles at best; no overlap of EMIT and accumulation.

Test Plan:
1. Reset: assert rst_n=0 asynchronously mid-cycle, then release. Required: out_valid=0, out_bits=0, in_ready=1 on the first post-reset cycle.
2. Uniform window (WINDOW=8, THRESH=5): 8 back-to-back samples of 7'b0000111 with out_ready=1. Required: out_valid=1 for exactly one cycle, the cycle after the 8th accept, with out_bits=7'b0000111 and out_samples=8.
3. Mixed vote: 5 samples of 7'b0111001, then 3 of 7'b0000111. Required: out_bits=7'b0111001.
   - bit0 count 8; bits 3,4,5 count 5; bits 1,2 count 3.
4. Backpressure: complete a window with out_ready=0 for 10 cycles while in_valid=1. Required:
   - out_valid held high with out_bits stable; in_ready=0; no samples accepted.
   - Raising out_ready completes the handshake, and in_ready=1 the next cycle.
5. Flush:
   - 4 samples of 7'b1111111, then flush=1 for one cycle together with in_valid=1, then 8 samples of 7'b0000000. Required: the flush-cycle sample is not accepted; one result, out_bits=7'b0000000.
   - Repeat with flush asserted in EMIT with out_ready=1. Required: no result transfer observed.
6. Reset mid-window: 6 samples of 7'b1000000, pulse rst_n low, then 8 samples of 7'b0000001. Required: the single result is 7'b0000001.

Source files
------------

// File: rtl/dtc_vote_accumulator_if.sv
// Sample-in / voted-result-out bus for the vote accumulator, plus its synchronous flush.
// The slave modport is the accumulator's view; the master modport is the driver's view.
interface dtc_vote_accumulator_if #(
  parameter int WIDTH = 7,
  parameter int CNT_W = 8
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_bits;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bits;
  logic [CNT_W-1:0] out_samples;

  modport master (
    output flush, in_valid, in_bits, out_ready,
    input  in_ready, out_valid, out_bits, out_samples
  );

  modport slave (
    input  flush, in_valid, in_bits, out_ready,
    output in_ready, out_valid, out_bits, out_samples
  );
endinterface

// File: rtl/dtc_vote_accumulator.sv
// Majority vote over WINDOW classifier samples; result valid the cycle after the last accept.
// While a result is pending in_ready is low, so upstream holds its sample; flush aborts either state.
module dtc_vote_accumulator #(
  parameter int WIDTH  = 7,
  parameter int WINDOW = 8,
  parameter int THRESH = 5,
  parameter int CNT_W  = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  dtc_vote_accumulator_if.slave  bus
);

  typedef enum logic {ACCUM = 1'b0, EMIT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hit_cnt_q [WIDTH];
  logic [CNT_W-1:0] hit_cnt_d [WIDTH];
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_bits_q, out_bits_d;
  logic [CNT_W-1:0] out_samples_q, out_samples_d;

  logic             in_ready;
  logic             accept;
  logic [CNT_W:0]   hit_sum;

  always_comb begin
    state_d       = state_q;
    hit_cnt_d     = hit_cnt_q;
    sample_cnt_d  = sample_cnt_q;
    out_valid_d   = out_valid_q;
    out_bits_d    = out_bits_q;
    out_samples_d = out_samples_q;
    hit_sum       = '0;

    in_ready = (state_q == ACCUM) && !bus.flush;
    accept   = bus.in_valid && in_ready;

    if (bus.flush) begin
      state_d      = ACCUM;
      sample_cnt_d = '0;
      out_valid_d  = 1'b0;
      for (int i = 0; i < WIDTH; i++) hit_cnt_d[i] = '0;
    end else if (state_q == ACCUM) begin
      if (accept) begin
        sample_cnt_d = sample_cnt_q + CNT_W'(1);
        for (int i = 0; i < WIDTH; i++) begin
          hit_cnt_d[i] = hit_cnt_q[i] + CNT_W'(bus.in_bits[i]);
        end
        // Final sample of the window: vote on the sum that includes it, then restart.
        if (sample_cnt_d == CNT_W'(WINDOW)) begin
          for (int i = 0; i < WIDTH; i++) begin
            hit_sum       = {1'b0, hit_cnt_q[i]} + (CNT_W+1)'(bus.in_bits[i]);
            out_bits_d[i] = (hit_sum >= (CNT_W+1)'(THRESH));
            hit_cnt_d[i]  = '0;
          end
          sample_cnt_d  = '0;
          out_samples_d = CNT_W'(WINDOW);
          out_valid_d   = 1'b1;
          state_d       = EMIT;
        end
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      state_d     = ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ACCUM;
      sample_cnt_q  <= '0;
      out_valid_q   <= 1'b0;
      out_bits_q    <= '0;
      out_samples_q <= '0;
      for (int i = 0; i < WIDTH; i++) hit_cnt_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      sample_cnt_q  <= sample_cnt_d;
      out_valid_q   <= out_valid_d;
      out_bits_q    <= out_bits_d;
      out_samples_q <= out_samples_d;
      hit_cnt_q     <= hit_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_bits    = out_bits_q;
  assign bus.out_samples = out_samples_q;

endmodule

// File: tb/tb_dtc_vote_accumulator.sv
// Directed bench for dtc_vote_accumulator: a window-queue model is compared every cycle,
// and per-scenario literal results pin both the model and the DUT.
module tb_dtc_vote_accumulator;
  localparam int WIDTH  = 7;
  localparam int WINDOW = 8;
  localparam int THRESH = 5;
  localparam int CNT_W  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  dtc_vote_accumulator_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  dtc_vote_accumulator #(
    .WIDTH(WIDTH), .WINDOW(WINDOW), .THRESH(THRESH), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: samples accepted in the open window, and a pending voted result.
  logic [WIDTH-1:0] m_win [$];
  bit               m_pend  = 1'b0;
  bit               m_fresh = 1'b1;
  logic [WIDTH-1:0] m_bits  = '0;
  logic [WIDTH-1:0] m_res [$];
  logic [WIDTH-1:0] d_res [$];
  int               d_samp [$];
  int               d_acc  = 0;
  int               d_vcyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] vote(input logic [WIDTH-1:0] q [$]);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < WIDTH; b++) begin
      int cnt;
      cnt = 0;
      foreach (q[k]) cnt += int'(q[k][b]);
      r[b] = (cnt >= THRESH);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_win.delete();
      m_pend  = 1'b0;
      m_fresh = 1'b1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_bits", bus.out_bits, 0);
      chk("rst_out_samples", bus.out_samples, 0);
    end else begin
      chk("in_ready", bus.in_ready, (!m_pend && !bus.flush));
      chk("out_valid", bus.out_valid, m_pend);
      if (m_pend) begin
        chk("out_bits", bus.out_bits, m_bits);
        chk("out_samples", bus.out_samples, WINDOW);
      end else if (m_fresh) begin
        chk("fresh_out_bits", bus.out_bits, 0);
        chk("fresh_out_samples", bus.out_samples, 0);
      end

      if (bus.in_valid && bus.in_ready) d_acc++;
      if (bus.out_valid) d_vcyc++;
      if (bus.out_valid && bus.out_ready && !bus.flush) begin
        d_res.push_back(bus.out_bits);
        d_samp.push_back(int'(bus.out_samples));
      end

      if (bus.flush) begin
        m_win.delete();
        m_pend = 1'b0;
      end else if (m_pend) begin
        if (bus.out_ready) begin
          m_res.push_back(m_bits);
          m_pend = 1'b0;
        end
      end else if (bus.in_valid) begin
        m_win.push_back(bus.in_bits);
        if (m_win.size() == WINDOW) begin
          m_bits  = vote(m_win);
          m_pend  = 1'b1;
          m_fresh = 1'b0;
          m_win.delete();
        end
      end
    end
  end

  // Present one sample and hold it until the DUT takes it (bounded).
  task automatic send(input logic [WIDTH-1:0] b);
    bit acc;
    int t;
    acc = 1'b0;
    t   = 0;
    bus.in_valid = 1'b1;
    bus.in_bits  = b;
    while (!acc && t < 40) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) chk("send_timeout", acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_one(input string name, input int dbase, input int mbase,
                            input logic [WIDTH-1:0] bits);
    chk({name, "_dut_count"}, d_res.size() - dbase, 1);
    if (d_res.size() > dbase) begin
      chk({name, "_dut_bits"}, d_res[dbase], bits);
      chk({name, "_dut_samples"}, d_samp[dbase], WINDOW);
    end
    chk({name, "_model_count"}, m_res.size() - mbase, 1);
    if (m_res.size() > mbase) chk({name, "_model_bits"}, m_res[mbase], bits);
  endtask

  initial begin
    int db, mb, a0, v0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bits   = '0;
    bus.out_ready = 1'b1;

    // Reset asserted and released away from the clock edge.
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle(2);

    // Uniform window.
    db = d_res.size(); mb = m_res.size(); v0 = d_vcyc;
    repeat (8) send(7'b0000111);
    idle(3);
    expect_one("uniform", db, mb, 7'b0000111);
    chk("uniform_valid_cycles", d_vcyc - v0, 1);

    // Mixed vote.
    db = d_res.size(); mb = m_res.size();
    repeat (5) send(7'b0111001);
    repeat (3) send(7'b0000111);
    idle(3);
    expect_one("mixed", db, mb, 7'b0111001);

    // Backpressure with upstream holding a sample.
    bus.out_ready = 1'b0;
    db = d_res.size(); mb = m_res.size();
    repeat (8) send(7'b1010101);
    bus.in_valid = 1'b1;
    bus.in_bits  = 7'b0101010;
    a0 = d_acc;
    idle(10);
    chk("bp_no_accept", d_acc - a0, 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    idle(3);
    expect_one("backpressure", db, mb, 7'b1010101);

    // Flush mid-window: flush-cycle sample rejected.
    db = d_res.size(); mb = m_res.size();
    repeat (4) send(7'b1111111);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_bits  = 7'b1111111;
    a0 = d_acc;
    idle(1);
    chk("flush_no_accept", d_acc - a0, 0);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    repeat (8) send(7'b0000000);
    idle(3);
    expect_one("flush_window", db, mb, 7'b0000000);

    // Flush in EMIT with out_ready high discards the result.
    bus.out_ready = 1'b0;
    db = d_res.size(); mb = m_res.size();
    repeat (8) send(7'b1111111);
    idle(1);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    idle(1);
    bus.flush = 1'b0;
    idle(4);
    chk("flush_emit_dut_count", d_res.size() - db, 0);
    chk("flush_emit_model_count", m_res.size() - mb, 0);

    // Reset mid-window drops the partial window.
    db = d_res.size(); mb = m_res.size();
    repeat (6) send(7'b1000000);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (8) send(7'b0000001);
    idle(3);
    expect_one("reset_mid", db, mb, 7'b0000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
